// File: rtl/mem_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_master_if
// Description : Signal bundle between the cores, the memory-bus initiator and
//               the data RAM pins.
//   Core side : REQ, REQ_WR, REQ_ADDR, REQ_WDATA (packed per core), ACK,
//               RDATA, ERR
//   RAM side  : ADDBUS, DATAIN, WR, RD (to RAM), DATAOUT (from RAM)
//   master    : view taken by mem_bus_master
//   slave     : view taken by cores/RAM (the environment)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_master_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
);
    logic [NUM_CORES-1:0]        REQ;
    logic [NUM_CORES-1:0]        REQ_WR;
    logic [NUM_CORES*ADDR_W-1:0] REQ_ADDR;
    logic [NUM_CORES*DATA_W-1:0] REQ_WDATA;
    logic [NUM_CORES-1:0]        ACK;
    logic [DATA_W-1:0]           RDATA;
    logic                        ERR;
    logic [ADDR_W-1:0]           ADDBUS;
    logic [DATA_W-1:0]           DATAIN;
    logic                        WR;
    logic                        RD;
    logic [DATA_W-1:0]           DATAOUT;

    modport master (
        input  REQ, REQ_WR, REQ_ADDR, REQ_WDATA, DATAOUT,
        output ACK, RDATA, ERR, ADDBUS, DATAIN, WR, RD
    );

    modport slave (
        output REQ, REQ_WR, REQ_ADDR, REQ_WDATA, DATAOUT,
        input  ACK, RDATA, ERR, ADDBUS, DATAIN, WR, RD
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_master
// Description : Round-robin initiator for the shared data-memory bus. Grants
//               one core at a time, sequences the RAM pins so the address is
//               stable a full cycle before a one-cycle WR/RD strobe, and
//               returns a one-cycle ACK (with RDATA/ERR) to the granted core.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : mem_bus_master_if.master (core handshake + RAM pins)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_master #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 1024
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    mem_bus_master_if.master     bus
);

    localparam int ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    // One extra bit so the range check also works when MEM_DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]    DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [NUM_CORES-1:0] ACK_ONE = {{(NUM_CORES-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]           state_q,  state_d;
    logic [ID_W-1:0]      ptr_q,    ptr_d;
    logic [ID_W-1:0]      id_q,     id_d;
    logic                 wr_op_q,  wr_op_d;
    logic [ADDR_W-1:0]    addbus_q, addbus_d;
    logic [DATA_W-1:0]    datain_q, datain_d;
    logic                 wr_q,     wr_d;
    logic                 rd_q,     rd_d;
    logic [NUM_CORES-1:0] ack_q,    ack_d;
    logic [DATA_W-1:0]    rdata_q,  rdata_d;
    logic                 err_q,    err_d;

    // ------------------------------------------------------------------
    // Per-core views of the packed request buses
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_addr_arr  [NUM_CORES];
    logic [DATA_W-1:0] w_wdata_arr [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign w_addr_arr[g]  = bus.REQ_ADDR[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = bus.REQ_WDATA[g*DATA_W +: DATA_W];
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first requester after the last granted core
    // ------------------------------------------------------------------
    logic            w_found;
    logic [ID_W-1:0] w_gnt_id;
    logic [ID_W-1:0] w_idx;

    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            w_idx = ID_W'((int'(ptr_q) + i) % NUM_CORES);
            if (!w_found && bus.REQ[w_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx;
            end
        end
    end

    logic [ADDR_W-1:0] w_gnt_addr;
    logic              w_addr_bad;

    assign w_gnt_addr = w_addr_arr[w_gnt_id];
    assign w_addr_bad = ({1'b0, w_gnt_addr} >= DEPTH_LIM);

    // ------------------------------------------------------------------
    // Next-state logic. Strobes and ACK default low so each is a single
    // cycle pulse set only on the transition into its owning state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        wr_op_d  = wr_op_q;
        addbus_d = addbus_q;
        datain_d = datain_q;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        ack_d    = '0;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (w_found) begin
                    id_d    = w_gnt_id;
                    ptr_d   = w_gnt_id;
                    wr_op_d = bus.REQ_WR[w_gnt_id];
                    if (w_addr_bad) begin
                        // Rejected: answer straight away, RAM pins untouched.
                        state_d = RESP;
                        ack_d   = ACK_ONE << w_gnt_id;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = SETUP;
                        addbus_d = w_gnt_addr;
                        datain_d = w_wdata_arr[w_gnt_id];
                    end
                end
            end
            SETUP: begin
                // Address has been stable for this whole cycle; strobe next.
                wr_d    = wr_op_q;
                rd_d    = !wr_op_q;
                state_d = wr_op_q ? WRITE : READ;
            end
            WRITE: begin
                state_d = RESP;
                ack_d   = ACK_ONE << id_q;
                err_d   = 1'b0;
            end
            READ: begin
                state_d = RESP;
                ack_d   = ACK_ONE << id_q;
                err_d   = 1'b0;
                rdata_d = bus.DATAOUT;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= ID_W'(NUM_CORES - 1);
            id_q     <= '0;
            wr_op_q  <= 1'b0;
            addbus_q <= '0;
            datain_q <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            ack_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            wr_op_q  <= wr_op_d;
            addbus_q <= addbus_d;
            datain_q <= datain_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign bus.ADDBUS = addbus_q;
    assign bus.DATAIN = datain_q;
    assign bus.WR     = wr_q;
    assign bus.RD     = rd_q;
    assign bus.ACK    = ack_q;
    assign bus.RDATA  = rdata_q;
    assign bus.ERR    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_master
// Description : Self-checking bench for mem_bus_master with a behavioural
//               RAM model and an expected-response queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_master;

    logic clk;
    logic rst_n;

    mem_bus_master_if #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16)) bus ();

    mem_bus_master #(
        .NUM_CORES(4),
        .ADDR_W   (16),
        .DATA_W   (16),
        .MEM_DEPTH(1024)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // RAM model: writes on the clock edge closing a WR cycle; read data
    // only presented while RD is high so a mistimed capture is visible.
    // ------------------------------------------------------------------
    logic [15:0] mem [0:1023];

    always @(posedge clk) begin
        if (bus.WR) mem[bus.ADDBUS[9:0]] <= bus.DATAIN;
    end

    assign bus.DATAOUT = bus.RD ? mem[bus.ADDBUS[9:0]] : 16'hDEAD;

    // ------------------------------------------------------------------
    // Pin activity monitor
    // ------------------------------------------------------------------
    int          rd_cycles, wr_cycles, overlap_cnt, ack_cnt;
    int          min_rd_gap, rd_gap_run;
    bit          seen_rd;
    logic [15:0] wr_addr, wr_data;

    always @(negedge clk) begin
        if (bus.ACK != 4'b0000) ack_cnt++;
        if (bus.RD && bus.WR) overlap_cnt++;
        if (bus.WR) begin
            wr_cycles++;
            wr_addr = bus.ADDBUS;
            wr_data = bus.DATAIN;
        end
        if (bus.RD) begin
            rd_cycles++;
            if (seen_rd && rd_gap_run < min_rd_gap) min_rd_gap = rd_gap_run;
            seen_rd    = 1'b1;
            rd_gap_run = 0;
        end else begin
            rd_gap_run++;
        end
    end

    task automatic clear_mon();
        rd_cycles   = 0;
        wr_cycles   = 0;
        overlap_cnt = 0;
        ack_cnt     = 0;
        min_rd_gap  = 1000;
        rd_gap_run  = 0;
        seen_rd     = 1'b0;
        wr_addr     = 16'h0;
        wr_data     = 16'h0;
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          id;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    // Stimulus-only helpers (no comparisons inside)
    task automatic set_core(input int c, input logic wr, input logic [15:0] addr,
                            input logic [15:0] wdata);
        bus.REQ_WR[c]            = wr;
        bus.REQ_ADDR[c*16 +: 16]  = addr;
        bus.REQ_WDATA[c*16 +: 16] = wdata;
    endtask

    // Count negedges from the current one until ACK is seen (bounded).
    task automatic wait_ack(output logic [3:0] ack, output int lat, output bit to);
        ack = 4'b0000;
        lat = 0;
        to  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.ACK != 4'b0000) begin
                ack = bus.ACK;
                lat = c;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        bus.REQ = 4'b0000;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        apply_reset();
        total++;
        if (bus.ACK !== 4'b0000 || bus.WR !== 1'b0 || bus.RD !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobes: ACK=%b WR=%b RD=%b required 0000/0/0", bus.ACK, bus.WR, bus.RD);
        end
        total++;
        if (bus.ADDBUS !== 16'h0 || bus.DATAIN !== 16'h0) begin
            bad++;
            $display("FAIL reset_bus: ADDBUS=%h DATAIN=%h required 0000/0000", bus.ADDBUS, bus.DATAIN);
        end
        total++;
        if (bus.RDATA !== 16'h0 || bus.ERR !== 1'b0) begin
            bad++;
            $display("FAIL reset_resp: RDATA=%h ERR=%b required 0000/0", bus.RDATA, bus.ERR);
        end
    endtask

    task automatic test_read();
        logic [3:0] ack;
        int         lat;
        bit         to;
        exp_t       e;
        clear_mon();
        set_core(0, 1'b0, 16'd5, 16'h0);
        sb.push_back('{id: 0, rdata: 16'h00AB, err: 1'b0});
        bus.REQ[0] = 1'b1;
        wait_ack(ack, lat, to);
        bus.REQ[0] = 1'b0;
        e = sb.pop_front();
        total++;
        if (to) begin
            bad++;
            $display("FAIL read_timeout: no ACK within 20 cycles");
        end
        total++;
        if (ack !== (4'b0001 << e.id) || bus.RDATA !== e.rdata || bus.ERR !== e.err) begin
            bad++;
            $display("FAIL read_resp: ACK=%b RDATA=%h ERR=%b required %b/%h/%b",
                     ack, bus.RDATA, bus.ERR, 4'b0001 << e.id, e.rdata, e.err);
        end
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL read_latency: %0d cycles, required 3", lat);
        end
        total++;
        if (rd_cycles !== 1 || wr_cycles !== 0) begin
            bad++;
            $display("FAIL read_strobes: RD cycles=%0d WR cycles=%0d, required 1/0", rd_cycles, wr_cycles);
        end
        @(negedge clk);
        total++;
        if (bus.ACK !== 4'b0000) begin
            bad++;
            $display("FAIL read_ack_len: ACK=%b after one cycle, required 0000", bus.ACK);
        end
    endtask

    task automatic test_write_read();
        logic [3:0] ack;
        int         lat;
        bit         to;
        exp_t       e;
        clear_mon();
        set_core(2, 1'b1, 16'd7, 16'h1234);
        sb.push_back('{id: 2, rdata: 16'h00AB, err: 1'b0}); // RDATA untouched by a write
        bus.REQ[2] = 1'b1;
        wait_ack(ack, lat, to);
        bus.REQ[2] = 1'b0;
        e = sb.pop_front();
        total++;
        if (to || ack !== (4'b0001 << e.id) || lat !== 3) begin
            bad++;
            $display("FAIL write_ack: ACK=%b latency=%0d timeout=%0b required %b/3/0",
                     ack, lat, to, 4'b0001 << e.id);
        end
        total++;
        if (bus.RDATA !== e.rdata || bus.ERR !== e.err) begin
            bad++;
            $display("FAIL write_resp: RDATA=%h ERR=%b required %h/%b", bus.RDATA, bus.ERR, e.rdata, e.err);
        end
        total++;
        if (wr_cycles !== 1 || rd_cycles !== 0 || wr_addr !== 16'd7 || wr_data !== 16'h1234) begin
            bad++;
            $display("FAIL write_pins: WR cycles=%0d RD cycles=%0d ADDBUS=%h DATAIN=%h required 1/0/0007/1234",
                     wr_cycles, rd_cycles, wr_addr, wr_data);
        end
        @(negedge clk);
        clear_mon();
        set_core(2, 1'b0, 16'd7, 16'h0);
        sb.push_back('{id: 2, rdata: 16'h1234, err: 1'b0});
        bus.REQ[2] = 1'b1;
        wait_ack(ack, lat, to);
        bus.REQ[2] = 1'b0;
        e = sb.pop_front();
        total++;
        if (to || ack !== (4'b0001 << e.id) || bus.RDATA !== e.rdata || rd_cycles !== 1) begin
            bad++;
            $display("FAIL readback: ACK=%b RDATA=%h RD cycles=%0d timeout=%0b required %b/%h/1/0",
                     ack, bus.RDATA, rd_cycles, to, 4'b0001 << e.id, e.rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  ack;
        int          lat;
        bit          to;
        exp_t        e;
        logic [15:0] rd_tab [4];
        rd_tab[0] = 16'h0003;
        rd_tab[1] = 16'h0004;
        rd_tab[2] = 16'h00AB;
        rd_tab[3] = 16'h0066;
        apply_reset();
        clear_mon();
        for (int c = 0; c < 4; c++) set_core(c, 1'b0, 16'(3 + c), 16'h0);
        for (int g = 0; g < 5; g++) sb.push_back('{id: g % 4, rdata: rd_tab[g % 4], err: 1'b0});
        bus.REQ = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_ack(ack, lat, to);
            e = sb.pop_front();
            total++;
            if (to || ack !== (4'b0001 << e.id) || bus.RDATA !== e.rdata || lat !== 3) begin
                bad++;
                $display("FAIL rr_grant%0d: ACK=%b RDATA=%h latency=%0d timeout=%0b required %b/%h/3/0",
                         g, ack, bus.RDATA, lat, to, 4'b0001 << e.id, e.rdata);
            end
            bus.REQ = bus.REQ & ~ack;
            if (g < 4) begin
                @(negedge clk);
                bus.REQ = bus.REQ | ack;
            end
        end
        bus.REQ = 4'b0000;
        total++;
        if (overlap_cnt !== 0 || rd_cycles !== 5 || wr_cycles !== 0) begin
            bad++;
            $display("FAIL rr_strobes: overlap=%0d RD cycles=%0d WR cycles=%0d required 0/5/0",
                     overlap_cnt, rd_cycles, wr_cycles);
        end
    endtask

    task automatic test_error();
        logic [3:0] ack;
        int         lat;
        bit         to;
        exp_t       e;
        @(negedge clk);
        clear_mon();
        set_core(1, 1'b0, 16'd1024, 16'h0);
        sb.push_back('{id: 1, rdata: 16'h0003, err: 1'b1}); // RDATA from previous read held
        bus.REQ[1] = 1'b1;
        wait_ack(ack, lat, to);
        bus.REQ[1] = 1'b0;
        e = sb.pop_front();
        total++;
        if (to || ack !== (4'b0001 << e.id) || lat !== 1) begin
            bad++;
            $display("FAIL err_ack: ACK=%b latency=%0d timeout=%0b required %b/1/0",
                     ack, lat, to, 4'b0001 << e.id);
        end
        total++;
        if (bus.ERR !== e.err || bus.RDATA !== e.rdata) begin
            bad++;
            $display("FAIL err_resp: ERR=%b RDATA=%h required %b/%h", bus.ERR, bus.RDATA, e.err, e.rdata);
        end
        repeat (3) @(negedge clk);
        total++;
        if (bus.ERR !== 1'b1 || bus.ACK !== 4'b0000 || rd_cycles !== 0 || wr_cycles !== 0) begin
            bad++;
            $display("FAIL err_hold: ERR=%b ACK=%b RD cycles=%0d WR cycles=%0d required 1/0000/0/0",
                     bus.ERR, bus.ACK, rd_cycles, wr_cycles);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ack;
        int         lat;
        bit         to;
        exp_t       e;
        clear_mon();
        set_core(0, 1'b0, 16'h0003, 16'h0);
        sb.push_back('{id: 0, rdata: 16'h0003, err: 1'b0});
        bus.REQ[0] = 1'b1;
        wait_ack(ack, lat, to);
        bus.REQ[0] = 1'b0;
        e = sb.pop_front();
        total++;
        if (to || ack !== (4'b0001 << e.id) || bus.RDATA !== e.rdata || bus.ERR !== e.err) begin
            bad++;
            $display("FAIL b2b_first: ACK=%b RDATA=%h ERR=%b timeout=%0b required %b/%h/%b/0",
                     ack, bus.RDATA, bus.ERR, to, 4'b0001 << e.id, e.rdata, e.err);
        end
        @(negedge clk);
        set_core(0, 1'b0, 16'h0004, 16'h0);
        sb.push_back('{id: 0, rdata: 16'h0004, err: 1'b0});
        bus.REQ[0] = 1'b1;
        wait_ack(ack, lat, to);
        bus.REQ[0] = 1'b0;
        e = sb.pop_front();
        total++;
        if (to || ack !== (4'b0001 << e.id) || bus.RDATA !== e.rdata || lat !== 3) begin
            bad++;
            $display("FAIL b2b_second: ACK=%b RDATA=%h latency=%0d timeout=%0b required %b/%h/3/0",
                     ack, bus.RDATA, lat, to, 4'b0001 << e.id, e.rdata);
        end
        total++;
        if (rd_cycles !== 2 || min_rd_gap < 2) begin
            bad++;
            $display("FAIL b2b_rd_gap: RD cycles=%0d min low gap=%0d required 2/>=2", rd_cycles, min_rd_gap);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ack;
        int         lat;
        bit         to;
        bit         got_rd;
        exp_t       e;
        @(negedge clk);
        set_core(0, 1'b0, 16'd5, 16'h0);
        bus.REQ[0] = 1'b1;
        got_rd = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.RD) begin
                got_rd = 1'b1;
                break;
            end
        end
        total++;
        if (!got_rd) begin
            bad++;
            $display("FAIL rstmid_rd: RD never rose, required a READ cycle");
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.RD !== 1'b0 || bus.WR !== 1'b0 || bus.ACK !== 4'b0000) begin
            bad++;
            $display("FAIL rstmid_drop: RD=%b WR=%b ACK=%b required 0/0/0000", bus.RD, bus.WR, bus.ACK);
        end
        bus.REQ = 4'b0000;
        clear_mon();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (ack_cnt !== 0) begin
            bad++;
            $display("FAIL rstmid_noack: %0d ACK cycles seen, required 0", ack_cnt);
        end
        // Core 3 also requesting: core 0 must win because reset restores priority.
        set_core(0, 1'b0, 16'd5, 16'h0);
        set_core(3, 1'b0, 16'd6, 16'h0);
        sb.push_back('{id: 0, rdata: 16'h00AB, err: 1'b0});
        sb.push_back('{id: 3, rdata: 16'h0066, err: 1'b0});
        bus.REQ = 4'b1001;
        wait_ack(ack, lat, to);
        bus.REQ = bus.REQ & ~ack;
        e = sb.pop_front();
        total++;
        if (to || ack !== (4'b0001 << e.id) || bus.RDATA !== e.rdata || lat !== 3) begin
            bad++;
            $display("FAIL rstmid_reissue: ACK=%b RDATA=%h latency=%0d timeout=%0b required %b/%h/3/0",
                     ack, bus.RDATA, lat, to, 4'b0001 << e.id, e.rdata);
        end
        wait_ack(ack, lat, to);
        bus.REQ = 4'b0000;
        e = sb.pop_front();
        total++;
        if (to || ack !== (4'b0001 << e.id) || bus.RDATA !== e.rdata || lat !== 4) begin
            bad++;
            $display("FAIL rstmid_next: ACK=%b RDATA=%h latency=%0d timeout=%0b required %b/%h/4/0",
                     ack, bus.RDATA, lat, to, 4'b0001 << e.id, e.rdata);
        end
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL sb_empty: %0d expected responses left, required 0", sb.size());
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b1;
        bus.REQ       = 4'b0000;
        bus.REQ_WR    = 4'b0000;
        bus.REQ_ADDR  = '0;
        bus.REQ_WDATA = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[3] = 16'h0003;
        mem[4] = 16'h0004;
        mem[5] = 16'h00AB;
        mem[6] = 16'h0066;
        clear_mon();
        @(negedge clk);

        test_reset();
        test_read();
        test_write_read();
        test_round_robin();
        test_error();
        test_back_to_back();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
Initiator side of the shared data-memory bus in the multicore processor.
- Arbitrates word read/write requests from NUM_CORES cores, round-robin.
- Drives the data RAM's ADDBUS/DATAIN/WR/RD pins and captures its DATAOUT.
- Returns read data or write completion to the granted core via a one-cycle ACK.
- Sequences every access so address is stable before RD rises, and RD returns low between accesses (RAM read path is level-change sensitive on RD).

Parameters:
NUM_CORES, 4, number of requesting cores
ADDR_W, 16, address width
DATA_W, 16, data word width
MEM_DEPTH, 1024, valid words; addresses >= MEM_DEPTH are rejected

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
REQ  input  NUM_CORES  per-core request; held high until that core's ACK
REQ_WR  input  NUM_CORES  per-core op: 1=write, 0=read; stable while REQ high
REQ_ADDR  input  NUM_CORES*ADDR_W  packed addresses, core i at [i*ADDR_W +: ADDR_W]
REQ_WDATA  input  NUM_CORES*DATA_W  packed write data, same packing
ACK  output  NUM_CORES  one-hot, one-cycle completion pulse to the granted core
RDATA  output  DATA_W  read data, valid while ACK high
ERR  output  1  high with ACK when the address was out of range
ADDBUS  output  ADDR_W  to RAM address
DATAIN  output  DATA_W  to RAM write data
WR  output  1  to RAM write strobe
RD  output  1  to RAM read strobe
DATAOUT  input  DATA_W  from RAM read data

Behaviour:
- All outputs registered.
- Reset (async, rst_n=0): state IDLE; ADDBUS=0, DATAIN=0, WR=0, RD=0, ACK=0, RDATA=0, ERR=0; rr pointer=NUM_CORES-1, so core 0 has first priority.
- FSM states: IDLE, SETUP, WRITE, READ, RESP.
- IDLE:
  - If any REQ is high, grant the first requester searching from pointer+1 (mod NUM_CORES).
  - Latch that core's id, addr, wdata and op; set pointer=id.
  - Address >= MEM_DEPTH: go to RESP with ERR=1; no WR/RD activity.
  - Otherwise go to SETUP.
  - No REQ: remain in IDLE, WR=RD=0.
- SETUP: ADDBUS=latched addr, DATAIN=latched wdata, WR=0, RD=0. Next state WRITE if op=write, else READ.
- WRITE: WR=1 for exactly one cycle; address and data held. RAM stores at the closing edge. Next state RESP.
- READ: RD=1 for exactly one cycle, address held. At the closing edge, capture DATAOUT into RDATA. Next state RESP.
- RESP:
  - WR=0, RD=0.
  - ACK[id]=1 for one cycle; RDATA holds read data (unchanged on writes); ERR as determined in IDLE.
  - Next state IDLE.
- Latency: REQ sampled at edge k → ACK high during cycle k+3. An error response is high during cycle k+1.
- Throughput: one access per 4 cycles; RD is always low for at least 2 cycles between reads.
- Core contract:
  - The core deasserts REQ on the edge where it sees ACK, so REQ is low by the next IDLE sample.
  - A REQ still high in IDLE is treated as a new request.
- ERR and RDATA hold their values until the next RESP; ACK is 0 outside RESP.
- Simultaneous requests are serviced in rotation from pointer+1. No core waits more than NUM_CORES grants.
- Changes to non-granted cores' inputs during an access are ignored. Granted inputs are latched in IDLE, so later changes have no effect.
- Reset mid-access: WR/RD drop to 0 immediately; the pending request is discarded, no ACK is issued, and the core must reissue. A write whose WR edge has not occurred is not performed.

Test Plan:
1. RAM preloaded mem[5]=16'h00AB; core0 reads addr 5 → RD high one cycle, ACK=4'b0001 at cycle k+3, RDATA=16'h00AB, ERR=0.
2. Core2 writes 16'h1234 to addr 7, then reads addr 7 → WR single-cycle pulse with ADDBUS=7 and DATAIN=16'h1234; the read returns RDATA=16'h1234.
3. REQ=4'b1111 held and re-raised after each ACK → ACK order core0,1,2,3,0, one grant per 4 cycles; RD/WR never overlap.
4. Core1 reads addr 16'd1024 → ACK=4'b0010 with ERR=1 at cycle k+1; WR and RD stay 0 throughout.
5. Back-to-back reads, addr 3 (16'h0003) then addr 4 (16'h0004) → RD low ≥2 cycles between pulses; RDATA=16'h0003 then 16'h0004.
6. rst_n pulled low during READ → RD=0 immediately, no ACK; after release, state IDLE, core0 has priority, and a reissued read completes normally.
